// File: rtl/dna_axil_if.sv
// AXI4-Lite bundle for the DNA register block.
// Carries 5-bit addresses and 32-bit data.
interface dna_axil_if;
   logic [4:0]  awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [4:0]  araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/dna_axil_regs.sv
// Captures the 96-bit device DNA from a serial reader and exposes it,
// together with control/status, through an AXI4-Lite register slave.
module dna_axil_regs #(
   parameter bit          AUTO_START     = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic      clk,
   input  logic      rst,
   output logic      start_dna_read,
   input  logic      ser_dna_in,
   input  logic      ser_dna_valid,
   dna_axil_if.slave s_axil
);
   localparam int unsigned DNA_W    = 96;
   localparam int unsigned CNT_W    = 8;
   localparam int unsigned WAIT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [31:0] ID_VALUE = 32'h444E_4131;

   typedef enum logic [2:0] {IDLE, START, WAIT, SHIFT, DONE, ERR} state_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
   logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
   logic [DNA_W-1:0]  r_shreg, w_shreg_nxt, w_shifted;
   logic [DNA_W-1:0]  r_dna_q, w_dna_nxt;
   logic              r_auto, w_auto_nxt;
   logic              r_start_dna_read;

   logic              r_awready, r_wready, r_bvalid;
   logic              r_arready, r_rvalid;
   logic [31:0]       r_rdata;
   logic              w_wr_go, w_wr_fire, w_start_wr;
   logic              w_rd_go, w_rd_fire, w_busy;
   logic [31:0]       w_status, w_rd_mux;
   logic              w_unused;

   assign w_shifted = {ser_dna_in, r_shreg[DNA_W-1:1]};
   assign w_busy    = (r_state == START) || (r_state == WAIT) || (r_state == SHIFT);
   assign w_status  = {16'h0, r_bit_cnt, 5'h0, (r_state == ERR), (r_state == DONE), w_busy};

   // Write accepted only once per transaction; the ready pulse itself blocks re-acceptance
   assign w_wr_go    = s_axil.awvalid && s_axil.wvalid && !r_bvalid && !r_awready;
   assign w_wr_fire  = r_awready && s_axil.awvalid && s_axil.wvalid;
   assign w_start_wr = w_wr_fire && (s_axil.awaddr[4:2] == 3'd0) && s_axil.wdata[0];
   assign w_rd_go    = s_axil.arvalid && !r_rvalid && !r_arready;
   assign w_rd_fire  = r_arready && s_axil.arvalid;

   assign w_unused = ^{s_axil.wstrb, s_axil.wdata[31:1], s_axil.awaddr[1:0], s_axil.araddr[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= IDLE;
         r_bit_cnt        <= '0;
         r_wait_cnt       <= '0;
         r_shreg          <= '0;
         r_dna_q          <= '0;
         r_auto           <= AUTO_START;
         r_start_dna_read <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_bit_cnt        <= w_bit_cnt_nxt;
         r_wait_cnt       <= w_wait_cnt_nxt;
         r_shreg          <= w_shreg_nxt;
         r_dna_q          <= w_dna_nxt;
         r_auto           <= w_auto_nxt;
         r_start_dna_read <= (w_state_nxt == START);
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_wait_cnt_nxt = r_wait_cnt;
      w_shreg_nxt    = r_shreg;
      w_dna_nxt      = r_dna_q;
      w_auto_nxt     = r_auto;
      case (r_state)
         IDLE: begin
            if (r_auto || w_start_wr) begin
               w_state_nxt = START;
               w_auto_nxt  = 1'b0;
            end
         end
         START: begin
            w_bit_cnt_nxt  = '0;
            w_wait_cnt_nxt = '0;
            w_shreg_nxt    = '0;
            w_state_nxt    = WAIT;
         end
         WAIT: begin
            w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
            if (ser_dna_valid) begin
               w_shreg_nxt   = w_shifted;
               w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
               w_state_nxt   = SHIFT;
            end else if (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
               w_state_nxt = ERR;
            end
         end
         SHIFT: begin
            if (ser_dna_valid) begin
               w_shreg_nxt   = w_shifted;
               w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
               if (r_bit_cnt == CNT_W'(DNA_W - 1)) begin
                  w_dna_nxt   = w_shifted;
                  w_state_nxt = DONE;
               end
            end else begin
               w_state_nxt = ERR;
            end
         end
         DONE, ERR: begin
            if (w_start_wr) w_state_nxt = START;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
      end else begin
         r_awready <= w_wr_go;
         r_wready  <= w_wr_go;
         if (w_wr_fire)          r_bvalid <= 1'b1;
         else if (s_axil.bready) r_bvalid <= 1'b0;
      end
   end

   // Read data is sampled at the address handshake, so it reflects pre-transition state
   always_comb begin
      w_rd_mux = '0;
      case (s_axil.araddr[4:2])
         3'd1:    w_rd_mux = w_status;
         3'd2:    w_rd_mux = r_dna_q[31:0];
         3'd3:    w_rd_mux = r_dna_q[63:32];
         3'd4:    w_rd_mux = r_dna_q[95:64];
         3'd5:    w_rd_mux = ID_VALUE;
         default: w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_arready <= w_rd_go;
         if (w_rd_fire) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_mux;
         end else if (s_axil.rready) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   assign start_dna_read = r_start_dna_read;
   assign s_axil.awready = r_awready;
   assign s_axil.wready  = r_wready;
   assign s_axil.bvalid  = r_bvalid;
   assign s_axil.bresp   = 2'b00;
   assign s_axil.arready = r_arready;
   assign s_axil.rvalid  = r_rvalid;
   assign s_axil.rdata   = r_rdata;
   assign s_axil.rresp   = 2'b00;
endmodule
